aq_gemac_tx_buff: RTL and testbench
===================================

// Module: aq_gemac_tx_buff
// PURPOSE
//  Transmit frame buffer feeding the TX MAC. Host side writes whole frames a byte at a time; the MAC side
//  reads them first-word-fall-through via BUFF_RD/BUFF_DATA/BUFF_EOP. Frames are held until the MAC
//  releases them (BUFF_FINISH), rewound on collision (BUFF_RETRY), or flushed after excess retries.
// PARAMETERS
//  ADDR_WIDTH   11  byte RAM depth = 2**ADDR_WIDTH; each entry is 9 bits {eop,data}
//  FCNT_WIDTH   6   width of committed-frame counter; max frames = 2**FCNT_WIDTH-1
// PORTS
//  RST_N        in   1   async active-low reset
//  CLK          in   1   single clock for both sides
//  WR_EN        in   1   host byte write strobe
//  WR_DATA      in   8   host byte
//  WR_EOP       in   1   qualifies WR_EN: last byte of frame
//  WR_FULL      out  1   no byte space, or frame counter at max
//  WR_DROP      out  1   1-cycle pulse: frame being written was discarded (overflow)
//  TX_REQ       out  1   >=1 committed frame pending and not flushing
//  BUFF_RD      in   1   MAC pops current byte
//  BUFF_DATA    out  8   byte at read pointer
//  BUFF_EOP     out  1   byte at read pointer is last of frame
//  BUFF_FINISH  in   1   MAC idle/defer level; used to release current frame
//  BUFF_RETRY   in   1   MAC in jam; level, may last many cycles
//  MAX_RETRY    in   4   same value as given to the MAC
//  FRAME_COUNT  out  FCNT_WIDTH  committed, unreleased frames
//  LEVEL        out  ADDR_WIDTH+1  bytes held (wr_ptr - rel_ptr)
// BEHAVIOUR
//  Reset: all pointers 0, FRAME_COUNT=0, LEVEL=0, WR_FULL=0, WR_DROP=0, TX_REQ=0, flags clear;
//   BUFF_DATA/BUFF_EOP reflect RAM at addr 0 (don't-care). Reset mid-frame discards everything.
//  Pointers (ADDR_WIDTH+1 bits, wrap modulo): wr_ptr, wr_start (start of frame in progress),
//   rd_ptr, rel_ptr (start of oldest unreleased frame). LEVEL = wr_ptr - rel_ptr.
//  Write: WR_EN & !WR_FULL stores {WR_EOP,WR_DATA} at wr_ptr, wr_ptr++. WR_EN & WR_FULL sets wr_bad,
//   byte not stored. On WR_EN & WR_EOP: if wr_bad (incl. this byte) -> wr_ptr<=wr_start, WR_DROP
//   pulse next cycle, wr_bad clear; else wr_start<=wr_ptr+1, FRAME_COUNT++ (commit).
//  WR_FULL = (LEVEL == 2**ADDR_WIDTH) | (FRAME_COUNT == max). Combinational from registers.
//  Read (FWFT): BUFF_DATA/BUFF_EOP = RAM[rd_ptr], valid whenever TX_REQ; BUFF_RD -> rd_ptr++, next
//   byte visible next cycle (0 latency, back-to-back reads every cycle). BUFF_RD with FRAME_COUNT=0 ignored.
//  Read-side FSM: IDLE, ACTIVE, DONE, FLUSH.
//   IDLE  : BUFF_RD -> ACTIVE. BUFF_FINISH ignored.
//   ACTIVE: BUFF_RD & BUFF_EOP -> DONE. BUFF_RETRY rising edge -> retry_cnt++.
//   DONE  : BUFF_FINISH -> release, IDLE. BUFF_RETRY rising edge -> retry_cnt++, ACTIVE.
//   Any state, BUFF_RETRY high: rd_ptr<=rel_ptr each cycle (retry wins over BUFF_RD).
//   ACTIVE & BUFF_FINISH: if retry_cnt >= MAX_RETRY+2 -> FLUSH (MAC dropped frame); else ignore (back-off).
//   FLUSH : TX_REQ=0; rd_ptr++ each cycle; on byte with eop -> release, IDLE.
//  Release: rel_ptr<=rd_ptr (post-EOP), FRAME_COUNT--, retry_cnt<=0. Commit and release same cycle:
//   FRAME_COUNT unchanged. retry_cnt 5 bits, saturates.
//  TX_REQ = (FRAME_COUNT != 0) & (state != FLUSH); registered-free, derived from registers.
// TESTING
//  1. Write 64-byte frame (0x00..0x3F, EOP on last) -> TX_REQ=1, FRAME_COUNT=1; read 64 -> BUFF_EOP on
//     0x3F; BUFF_FINISH -> FRAME_COUNT=0, LEVEL=0, TX_REQ=0.
//  2. Read 20 bytes, BUFF_RETRY high 17 cycles, FINISH (retry_cnt=1, MAX_RETRY=15) -> no release;
//     reads restart at 0x00, full 64 re-read, FINISH releases.
//  3. MAX_RETRY=0: two retry episodes then FINISH -> FLUSH, TX_REQ=0 until EOP passed, FRAME_COUNT=0.
//  4. ADDR_WIDTH=6: write 70-byte frame -> WR_FULL at 64, WR_DROP pulse after EOP, LEVEL=0, FRAME_COUNT=0.
//  5. Write frame 2 while frame 1 is read and released same cycle as frame 2 commit -> FRAME_COUNT stays 1,
//     frame 2 reads intact across pointer wrap.
//  6. Assert RST_N low mid-read -> all outputs reset values, subsequent frame reads from address 0.

Source files
------------

// File: rtl/aq_gemac_tx_buff.sv
// ----------------------------------------------------------------------------
// aq_gemac_tx_buff
//
// Transmit frame buffer between the host and the TX MAC.
//
// The host writes whole frames one byte at a time. A frame becomes visible to
// the MAC only when its last byte (WR_EOP) has been written. If any byte of a
// frame does not fit, the whole frame is discarded and WR_DROP pulses.
//
// The MAC reads the oldest committed frame first-word-fall-through. The frame
// stays in the buffer until the MAC has read it through EOP and signals
// BUFF_FINISH. BUFF_RETRY rewinds the read pointer to the start of the frame.
// Once the MAC has given up on the frame after too many retries, the frame is
// skipped byte by byte (FLUSH) and then released.
//
// Parameters
//   ADDR_WIDTH   byte RAM depth is 2**ADDR_WIDTH; each entry is {eop, data}
//   FCNT_WIDTH   width of the committed-frame counter
//
// Ports
//   RST_N        async active-low reset
//   CLK          single clock for both sides
//   WR_EN        host byte write strobe
//   WR_DATA      host byte
//   WR_EOP       with WR_EN: last byte of the frame
//   WR_FULL      no byte space left, or frame counter at its maximum
//   WR_DROP      one-cycle pulse: the frame being written was discarded
//   TX_REQ       at least one committed frame pending and not flushing
//   BUFF_RD      MAC pops the current byte
//   BUFF_DATA    byte at the read pointer
//   BUFF_EOP     byte at the read pointer is the last byte of its frame
//   BUFF_FINISH  MAC idle/defer level; releases the frame once it is done
//   BUFF_RETRY   MAC jam level; rewinds the frame while high
//   MAX_RETRY    retry limit, same value as given to the MAC
//   FRAME_COUNT  committed, unreleased frames
//   LEVEL        bytes held (wr_ptr - rel_ptr)
// ----------------------------------------------------------------------------
module aq_gemac_tx_buff #(
    parameter int ADDR_WIDTH = 11,
    parameter int FCNT_WIDTH = 6
) (
    input  logic                  RST_N,
    input  logic                  CLK,
    input  logic                  WR_EN,
    input  logic [7:0]            WR_DATA,
    input  logic                  WR_EOP,
    output logic                  WR_FULL,
    output logic                  WR_DROP,
    output logic                  TX_REQ,
    input  logic                  BUFF_RD,
    output logic [7:0]            BUFF_DATA,
    output logic                  BUFF_EOP,
    input  logic                  BUFF_FINISH,
    input  logic                  BUFF_RETRY,
    input  logic [3:0]            MAX_RETRY,
    output logic [FCNT_WIDTH-1:0] FRAME_COUNT,
    output logic [ADDR_WIDTH:0]   LEVEL
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    // Pointers carry one extra bit so a completely full RAM is distinguishable
    // from an empty one.
    localparam logic [PTR_W-1:0]      DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PTR_W-1:0]      PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [FCNT_WIDTH-1:0] FCNT_MAX  = '1;
    localparam logic [FCNT_WIDTH-1:0] FCNT_ONE  = {{(FCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [4:0]            RETRY_SAT = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE,
        ST_FLUSH
    } rd_state_t;

    logic [8:0]            mem [2**ADDR_WIDTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      wr_start;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rel_ptr;
    logic [FCNT_WIDTH-1:0] frame_count;
    logic                  wr_bad;
    logic                  wr_drop;
    logic [4:0]            retry_cnt;
    logic                  retry_prev;
    rd_state_t             state;
    rd_state_t             state_next;

    logic [PTR_W-1:0]      level;
    logic                  wr_full;
    logic                  wr_store;
    logic                  wr_overflow;
    logic                  wr_end;
    logic                  frame_bad;
    logic                  commit;
    logic                  drop;

    logic [8:0]            rd_entry;
    logic                  has_frame;
    logic                  retry_rise;
    logic                  rd_pop;
    logic                  retry_limit;
    logic                  release_frame;
    logic                  retry_inc;
    logic                  flush_step;
    logic [PTR_W-1:0]      release_ptr;
    logic [PTR_W-1:0]      rd_ptr_next;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign level       = wr_ptr - rel_ptr;
    assign wr_full     = (level == DEPTH) | (frame_count == FCNT_MAX);
    assign wr_store    = WR_EN & ~wr_full;
    assign wr_overflow = WR_EN & wr_full;
    assign wr_end      = WR_EN & WR_EOP;
    // The overflowing byte itself counts, so a frame whose EOP byte is the
    // first one not to fit is still dropped.
    assign frame_bad   = wr_bad | wr_overflow;
    assign commit      = wr_end & ~frame_bad;
    assign drop        = wr_end & frame_bad;

    always_ff @(posedge CLK) begin
        if (wr_store) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {WR_EOP, WR_DATA};
        end
    end

    // A dropped frame is undone by winding wr_ptr back to the frame start;
    // bytes already stored are simply overwritten by the next frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            wr_start <= '0;
            wr_bad   <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            wr_drop <= drop;
            if (drop) begin
                wr_ptr <= wr_start;
                wr_bad <= 1'b0;
            end else begin
                if (wr_store) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (wr_overflow) begin
                    wr_bad <= 1'b1;
                end
            end
            if (commit) begin
                wr_start <= wr_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign rd_entry    = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign has_frame   = (frame_count != '0);
    assign retry_rise  = BUFF_RETRY & ~retry_prev;
    // Pops are only honoured while a frame is being read out; a jam in the
    // same cycle wins over the pop.
    assign rd_pop      = BUFF_RD & has_frame & ~BUFF_RETRY &
                         ((state == ST_IDLE) | (state == ST_ACTIVE));
    // The MAC drops the frame after MAX_RETRY+1 retransmissions, i.e. once
    // it has seen MAX_RETRY+2 collisions.
    assign retry_limit = ({1'b0, retry_cnt} >= ({2'b00, MAX_RETRY} + 6'd2));

    always_comb begin
        state_next    = state;
        release_frame = 1'b0;
        retry_inc     = 1'b0;
        flush_step    = 1'b0;
        release_ptr   = rd_ptr;
        case (state)
            ST_IDLE: begin
                // A one-byte frame completes on its first pop.
                if (rd_pop) begin
                    state_next = BUFF_EOP ? ST_DONE : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (retry_rise) begin
                    retry_inc = 1'b1;
                end else if (BUFF_FINISH & retry_limit) begin
                    state_next = ST_FLUSH;
                end else if (rd_pop & BUFF_EOP) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (retry_rise) begin
                    retry_inc  = 1'b1;
                    state_next = ST_ACTIVE;
                end else if (BUFF_FINISH) begin
                    release_frame = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                flush_step = ~BUFF_RETRY;
                if (flush_step & BUFF_EOP) begin
                    release_frame = 1'b1;
                    release_ptr   = rd_ptr + PTR_ONE;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_ptr_next = rd_ptr;
        if (BUFF_RETRY) begin
            rd_ptr_next = rel_ptr;
        end else if (rd_pop | flush_step) begin
            rd_ptr_next = rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            rd_ptr     <= '0;
            rel_ptr    <= '0;
            retry_cnt  <= '0;
            retry_prev <= 1'b0;
        end else begin
            state      <= state_next;
            rd_ptr     <= rd_ptr_next;
            retry_prev <= BUFF_RETRY;
            if (release_frame) begin
                rel_ptr   <= release_ptr;
                retry_cnt <= '0;
            end else if (retry_inc && (retry_cnt != RETRY_SAT)) begin
                retry_cnt <= retry_cnt + 5'd1;
            end
        end
    end

    // Commit and release in the same cycle cancel out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_count <= '0;
        end else begin
            case ({commit, release_frame})
                2'b10:   frame_count <= frame_count + FCNT_ONE;
                2'b01:   frame_count <= frame_count - FCNT_ONE;
                default: frame_count <= frame_count;
            endcase
        end
    end

    assign WR_FULL     = wr_full;
    assign WR_DROP     = wr_drop;
    assign TX_REQ      = has_frame & (state != ST_FLUSH);
    assign BUFF_DATA   = rd_entry[7:0];
    assign BUFF_EOP    = rd_entry[8];
    assign FRAME_COUNT = frame_count;
    assign LEVEL       = level;

endmodule

// File: tb/tb_aq_gemac_tx_buff.sv
// ----------------------------------------------------------------------------
// tb_aq_gemac_tx_buff
//
// Directed bench for aq_gemac_tx_buff with a 64-byte buffer. Written bytes go
// into a model queue; committed frames are compared byte by byte as the MAC
// side reads them, and popped from the model when the frame is released.
// ----------------------------------------------------------------------------
module tb_aq_gemac_tx_buff;

    localparam int AW    = 6;
    localparam int FW    = 6;
    localparam int DEPTH = 2**AW;
    localparam int FMAX  = 2**FW - 1;

    logic          RST_N;
    logic          CLK;
    logic          WR_EN;
    logic [7:0]    WR_DATA;
    logic          WR_EOP;
    logic          WR_FULL;
    logic          WR_DROP;
    logic          TX_REQ;
    logic          BUFF_RD;
    logic [7:0]    BUFF_DATA;
    logic          BUFF_EOP;
    logic          BUFF_FINISH;
    logic          BUFF_RETRY;
    logic [3:0]    MAX_RETRY;
    logic [FW-1:0] FRAME_COUNT;
    logic [AW:0]   LEVEL;

    int tests_run;
    int failures;

    logic [8:0] exp_q[$];
    logic [8:0] pend_q[$];
    int         rd_idx;
    int         model_fc;
    logic       wr_bad_m;

    aq_gemac_tx_buff #(
        .ADDR_WIDTH (AW),
        .FCNT_WIDTH (FW)
    ) dut (
        .RST_N       (RST_N),
        .CLK         (CLK),
        .WR_EN       (WR_EN),
        .WR_DATA     (WR_DATA),
        .WR_EOP      (WR_EOP),
        .WR_FULL     (WR_FULL),
        .WR_DROP     (WR_DROP),
        .TX_REQ      (TX_REQ),
        .BUFF_RD     (BUFF_RD),
        .BUFF_DATA   (BUFF_DATA),
        .BUFF_EOP    (BUFF_EOP),
        .BUFF_FINISH (BUFF_FINISH),
        .BUFF_RETRY  (BUFF_RETRY),
        .MAX_RETRY   (MAX_RETRY),
        .FRAME_COUNT (FRAME_COUNT),
        .LEVEL       (LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // One clock of stimulus. Register-derived outputs are checked before
    // the edge, the write model and read index are updated alongside.
    task automatic apply_stimulus(input logic wr_en, input logic [7:0] wr_data, input logic wr_eop,
                                  input logic rd, input logic finish, input logic retry);
        logic       full_m;
        logic       drop_m;
        logic [8:0] exp_entry;
        drop_m      = 1'b0;
        WR_EN       = wr_en;
        WR_DATA     = wr_data;
        WR_EOP      = wr_eop;
        BUFF_RD     = rd;
        BUFF_FINISH = finish;
        BUFF_RETRY  = retry;
        if (rd) begin
            exp_entry = (rd_idx < exp_q.size()) ? exp_q[rd_idx] : 9'h1FF;
            check_output("tx_req_rd", 32'(TX_REQ), 32'd1);
            check_output("buff_data", 32'(BUFF_DATA), 32'(exp_entry[7:0]));
            check_output("buff_eop", 32'(BUFF_EOP), 32'(exp_entry[8]));
        end
        if (wr_en) begin
            full_m = ((exp_q.size() + pend_q.size()) >= DEPTH) || (model_fc == FMAX);
            check_output("wr_full", 32'(WR_FULL), 32'(full_m));
            if (full_m) wr_bad_m = 1'b1;
            else pend_q.push_back({wr_eop, wr_data});
            if (wr_eop) begin
                if (wr_bad_m) begin
                    drop_m   = 1'b1;
                    wr_bad_m = 1'b0;
                    pend_q.delete();
                end else begin
                    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                    pend_q.delete();
                    model_fc++;
                end
            end
        end
        cycle();
        if (wr_en && wr_eop) check_output("wr_drop", 32'(WR_DROP), 32'(drop_m));
        if (retry) rd_idx = 0;
        else if (rd) rd_idx++;
    endtask

    task automatic idle_step();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write_frame(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b1, base + 8'(i), (i == n - 1), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic read_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic retry_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        idle_step();
    endtask

    task automatic release_model();
        logic [8:0] e;
        int         popped;
        popped = 0;
        e      = 9'h000;
        while (!e[8] && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
        end
        model_fc--;
        rd_idx = (rd_idx > popped) ? rd_idx - popped : 0;
    endtask

    task automatic check_counts(input string tag);
        check_output({tag, "_frame_count"}, 32'(FRAME_COUNT), 32'(model_fc));
        check_output({tag, "_level"}, 32'(LEVEL), 32'(exp_q.size() + pend_q.size()));
        check_output({tag, "_tx_req"}, 32'(TX_REQ), 32'(model_fc != 0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_frame_count"}, 32'(FRAME_COUNT), 32'd0);
        check_output({tag, "_level"}, 32'(LEVEL), 32'd0);
        check_output({tag, "_wr_full"}, 32'(WR_FULL), 32'd0);
        check_output({tag, "_wr_drop"}, 32'(WR_DROP), 32'd0);
        check_output({tag, "_tx_req"}, 32'(TX_REQ), 32'd0);
    endtask

    initial begin
        int n;
        tests_run   = 0;
        failures    = 0;
        rd_idx      = 0;
        model_fc    = 0;
        wr_bad_m    = 1'b0;
        RST_N       = 1'b0;
        WR_EN       = 1'b0;
        WR_DATA     = 8'h00;
        WR_EOP      = 1'b0;
        BUFF_RD     = 1'b0;
        BUFF_FINISH = 1'b0;
        BUFF_RETRY  = 1'b0;
        MAX_RETRY   = 4'd15;

        // Reset
        cycle();
        cycle();
        check_reset_outputs("reset");
        RST_N = 1'b1;
        cycle();

        // 1: single 64-byte frame, read out and released
        write_frame(64, 8'h00);
        check_counts("t1_written");
        check_output("t1_wr_full", 32'(WR_FULL), 32'd1);
        read_bytes(64);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        release_model();
        check_counts("t1_released");

        // 2: retry below the limit rewinds, FINISH in back-off is ignored
        MAX_RETRY = 4'd15;
        write_frame(64, 8'h00);
        read_bytes(20);
        retry_cycles(17);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check_counts("t2_backoff");
        read_bytes(64);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        release_model();
        check_counts("t2_released");

        // 3: MAX_RETRY=0, two collisions then FINISH flushes the frame
        MAX_RETRY = 4'd0;
        write_frame(64, 8'h80);
        read_bytes(10);
        retry_cycles(3);
        read_bytes(5);
        retry_cycles(3);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("t3_flush_tx_req", 32'(TX_REQ), 32'd0);
        check_output("t3_flush_fc", 32'(FRAME_COUNT), 32'd1);
        n = 0;
        while (FRAME_COUNT != 0 && n < 200) begin
            check_output("t3_tx_req_during_flush", 32'(TX_REQ), 32'd0);
            idle_step();
            n++;
        end
        check_output("t3_flush_cycles", 32'(n), 32'd64);
        release_model();
        check_counts("t3_flushed");

        // 4: 70-byte frame overflows the 64-byte RAM and is dropped
        MAX_RETRY = 4'd15;
        for (int i = 0; i < 70; i++) begin
            apply_stimulus(1'b1, 8'(i), (i == 69), 1'b0, 1'b0, 1'b0);
            if (i == 63) begin
                check_output("t4_level_full", 32'(LEVEL), 32'd64);
                check_output("t4_wr_full", 32'(WR_FULL), 32'd1);
            end
        end
        check_counts("t4_dropped");
        idle_step();
        check_output("t4_drop_pulse_end", 32'(WR_DROP), 32'd0);

        // 5: frame 2 written while frame 1 is read; commit and release coincide
        write_frame(40, 8'hC0);
        read_bytes(40);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        release_model();
        write_frame(20, 8'h20);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 8'h50 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 20; i < 29; i++) begin
            apply_stimulus(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        apply_stimulus(1'b1, 8'h50 + 8'd29, 1'b1, 1'b0, 1'b1, 1'b0);
        release_model();
        check_counts("t5_overlap");
        check_output("t5_fc_one", 32'(FRAME_COUNT), 32'd1);
        read_bytes(30);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        release_model();
        check_counts("t5_released");

        // 6: reset in the middle of a read discards everything
        write_frame(16, 8'h40);
        read_bytes(5);
        BUFF_RD = 1'b0;
        RST_N   = 1'b0;
        #2;
        check_reset_outputs("t6_in_reset");
        exp_q.delete();
        pend_q.delete();
        rd_idx   = 0;
        model_fc = 0;
        wr_bad_m = 1'b0;
        cycle();
        RST_N = 1'b1;
        cycle();
        check_reset_outputs("t6_after_reset");
        write_frame(10, 8'hA0);
        check_counts("t6_written");
        read_bytes(10);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        release_model();
        check_counts("t6_released");

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
